// File: rtl/imem_responder.sv
// Instruction-memory responder for the IF stage.
// Serves one outstanding fetch at a time from a word-addressed program store.
// Inserts WAIT_CYCLES wait states and drops in-flight work on a flush.
// Fetches that are misaligned or outside the store come back as a NOP with
// resp_fault set.
module imem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1   // 0..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_inst,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_fault,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data
);

  localparam int unsigned          DEPTH     = 32'd1 << DEPTH_LOG2;
  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);
  localparam logic [3:0]           WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // With no wait states an accepted fetch goes straight to the response slot.
  localparam state_e     START_STATE = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
  localparam logic [3:0] START_CNT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'd1;

  // A fetch is faulty when it is not word aligned or lands above the store.
  // This covers the post-reset PC sentinel 0xFFFFFFFC.
  function automatic logic fetch_fault(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] hi_s;
    hi_s = addr >> (DEPTH_LOG2 + 2);
    return (addr[1:0] != 2'b00) || (hi_s != '0);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_e                state_r;
  state_e                state_nx_s;
  logic [3:0]            wait_cnt_r;
  logic [3:0]            wait_cnt_nx_s;
  logic                  req_ready_s;
  logic                  accept_s;
  logic                  fault_s;
  logic [DEPTH_LOG2-1:0] rd_idx_s;
  logic [DEPTH_LOG2-1:0] wr_idx_s;
  logic                  resp_valid_r;
  logic [DATA_WIDTH-1:0] resp_inst_r;
  logic [ADDR_WIDTH-1:0] resp_addr_r;
  logic                  resp_fault_r;
  logic                  prog_addr_unused_s;

  // The byte lane and the bits above the store are ignored on program writes.
  assign prog_addr_unused_s = ^{prog_addr[1:0], prog_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]};

  assign rd_idx_s = req_addr[DEPTH_LOG2+1:2];
  assign wr_idx_s = prog_addr[DEPTH_LOG2+1:2];
  assign fault_s  = fetch_fault(req_addr);

  // Request acceptance.
  // A flush blocks acceptance outright. A held response must be consumed
  // before the next fetch can be taken.
  always_comb begin
    req_ready_s = 1'b0;
    if (flush) begin
      req_ready_s = 1'b0;
    end else begin
      req_ready_s = (state_r == S_IDLE) || ((state_r == S_RESP) && resp_ready);
    end
    accept_s = req_valid && req_ready_s;
  end

  // Next state and wait counter. A flush overrides every transition.
  always_comb begin
    state_nx_s    = state_r;
    wait_cnt_nx_s = 4'd0;
    if (flush) begin
      state_nx_s    = S_IDLE;
      wait_cnt_nx_s = 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            state_nx_s    = START_STATE;
            wait_cnt_nx_s = START_CNT;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt_r >= WAIT_LAST) begin
            state_nx_s = S_RESP;
          end else begin
            state_nx_s    = S_WAIT;
            wait_cnt_nx_s = wait_cnt_r + 4'd1;
          end
        end
        S_RESP: begin
          if (accept_s) begin
            state_nx_s    = START_STATE;
            wait_cnt_nx_s = START_CNT;
          end else if (resp_ready) begin
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = S_RESP;
          end
        end
        default: begin
          state_nx_s = S_IDLE;
        end
      endcase
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nx_s;
      wait_cnt_r <= wait_cnt_nx_s;
    end
  end

  // Program store write port. The store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_r[wr_idx_s] <= prog_data;
    end
  end

  // Response registers.
  // Data is captured at accept, reading the store before a same-edge write.
  // The data then holds until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_inst_r  <= NOP_INST;
      resp_addr_r  <= '0;
      resp_fault_r <= 1'b0;
    end else begin
      resp_valid_r <= (state_nx_s == S_RESP);
      if (accept_s) begin
        resp_addr_r  <= req_addr;
        resp_fault_r <= fault_s;
        resp_inst_r  <= fault_s ? NOP_INST : mem_r[rd_idx_s];
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_r;
  assign resp_inst  = resp_inst_r;
  assign resp_addr  = resp_addr_r;
  assign resp_fault = resp_fault_r;

endmodule
